multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback for one instruction at a time. It classifies the latched instruction by opcode `IR[6:2]`, drives every datapath select (ALU operands, PC source, writeback source), and runs the request/ready handshakes to instruction and data memory. It sits beside the immediate generator, register file and ALU, and owns all their write enables.

---
 rtl/ctrl_pkg.sv | 55 +++++
 rtl/ctrl_decode.sv | 35 +++
 rtl/multicycle_ctrl.sv | 175 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: opcodes, states,
// datapath select encodings and the instruction class vector.
package ctrl_pkg;

    localparam int unsigned OPC_W = 5;

    localparam logic [OPC_W-1:0] OPC_LOAD     = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AUIPC    = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_STORE    = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_OP       = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_LUI      = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_BRANCH   = 5'b11000;
    localparam logic [OPC_W-1:0] OPC_JALR     = 5'b11001;
    localparam logic [OPC_W-1:0] OPC_JAL      = 5'b11011;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    localparam logic B_RS2 = 1'b0;
    localparam logic B_IMM = 1'b1;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    typedef struct packed {
        logic op;
        logic op_imm;
        logic lui;
        logic auipc;
        logic load;
        logic store;
        logic jal;
        logic jalr;
        logic branch;
        logic misc_mem;
    } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: one-hot class, legality and rd==x0.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output iclass_t     cls,
    output logic        legal,
    output logic        rd_zero
);

    logic [OPC_W-1:0] opc;
    logic             unused_ir_hi;

    assign opc          = ir[6:2];
    assign rd_zero      = (ir[11:7] == 5'd0);
    assign unused_ir_hi = ^ir[31:12];

    always_comb begin
        cls          = '0;
        cls.op       = (opc == OPC_OP);
        cls.op_imm   = (opc == OPC_OP_IMM);
        cls.lui      = (opc == OPC_LUI);
        cls.auipc    = (opc == OPC_AUIPC);
        cls.load     = (opc == OPC_LOAD);
        cls.store    = (opc == OPC_STORE);
        cls.jal      = (opc == OPC_JAL);
        cls.jalr     = (opc == OPC_JALR);
        cls.branch   = (opc == OPC_BRANCH);
        cls.misc_mem = (opc == OPC_MISC_MEM);
    end

    // Compressed encodings (ir[1:0] != 2'b11) are not supported.
    assign legal = (ir[1:0] == 2'b11) && (|cls);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback
// sequencing, datapath selects and imem/dmem request handshakes.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        br_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic        alu_add,
    output logic [1:0]  wb_sel,
    output logic        rf_we,
    output logic        retire,
    output logic        illegal
);

    state_e     state, state_next;
    iclass_t    cls;
    logic       legal, rd_zero;
    logic       illegal_q;
    logic [1:0] op_a;
    logic       op_b, op_add;

    ctrl_decode u_decode (
        .ir      (ir),
        .cls     (cls),
        .legal   (legal),
        .rd_zero (rd_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DECODE && !legal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign illegal = illegal_q;

    // ALU operand selects per class; held from EXEC through MEM/WB.
    always_comb begin
        op_a   = A_RS1;
        op_b   = B_RS2;
        op_add = 1'b0;
        if (cls.op_imm) begin
            op_b = B_IMM;
        end else if (cls.lui) begin
            op_a   = A_ZERO;
            op_b   = B_IMM;
            op_add = 1'b1;
        end else if (cls.auipc) begin
            op_a   = A_PC;
            op_b   = B_IMM;
            op_add = 1'b1;
        end else if (cls.load || cls.store || cls.jalr) begin
            op_b   = B_IMM;
            op_add = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_PLUS4;
        alu_a_sel  = A_RS1;
        alu_b_sel  = B_RS2;
        alu_add    = 1'b0;
        wb_sel     = WB_ALU;
        rf_we      = 1'b0;
        retire     = 1'b0;

        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                alu_a_sel = op_a;
                alu_b_sel = op_b;
                alu_add   = op_add;
                if (cls.op || cls.op_imm || cls.lui || cls.auipc) begin
                    state_next = S_WB;
                end else if (cls.load || cls.store) begin
                    state_next = S_MEM;
                end else begin
                    // Control transfers and FENCE complete here.
                    pc_we      = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                    if (cls.jal || cls.jalr) begin
                        pc_src = cls.jal ? PC_IMM : PC_ALU;
                        rf_we  = !rd_zero;
                        wb_sel = WB_PC4;
                    end else if (cls.branch) begin
                        pc_src = br_taken ? PC_IMM : PC_PLUS4;
                    end
                end
            end
            S_MEM: begin
                alu_a_sel = op_a;
                alu_b_sel = op_b;
                alu_add   = op_add;
                dmem_req  = 1'b1;
                dmem_we   = cls.store;
                if (dmem_ready) begin
                    if (cls.store) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                alu_a_sel  = op_a;
                alu_b_sel  = op_b;
                alu_add    = op_add;
                wb_sel     = cls.load ? WB_LOAD : WB_ALU;
                rf_we      = !rd_zero;
                pc_we      = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Reset silences every request immediately, including the FETCH request.
        if (!rst_n) begin
            imem_req  = 1'b0;
            ir_we     = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            pc_we     = 1'b0;
            pc_src    = PC_PLUS4;
            alu_a_sel = A_RS1;
            alu_b_sel = B_RS2;
            alu_add   = 1'b0;
            wb_sel    = WB_ALU;
            rf_we     = 1'b0;
            retire    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: hand-computed output vectors per cycle.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] ir;
    logic        br_taken, imem_ready, dmem_ready;
    logic        imem_req, ir_we, dmem_req, dmem_we, pc_we;
    logic [1:0]  pc_src, alu_a_sel, wb_sel;
    logic        alu_b_sel, alu_add, rf_we, retire, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_LW    = 32'h0000_A103;
    localparam logic [31:0] I_BEQ   = 32'h0000_0463;
    localparam logic [31:0] I_JAL0  = 32'h0000_006F;
    localparam logic [31:0] I_AUIPC = 32'h0000_1097;
    localparam logic [31:0] I_SW    = 32'h0020_A023;
    localparam logic [31:0] I_ZERO  = 32'h0000_0000;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir         (ir),
        .br_taken   (br_taken),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_we      (ir_we),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .alu_a_sel  (alu_a_sel),
        .alu_b_sel  (alu_b_sel),
        .alu_add    (alu_add),
        .wb_sel     (wb_sel),
        .rf_we      (rf_we),
        .retire     (retire),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] outs;
    assign outs = {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src, alu_a_sel,
                   alu_b_sel, alu_add, wb_sel, rf_we, retire, illegal};

    // Expected vector: imem_req ir_we dmem_req dmem_we pc_we pc_src a_sel b_sel add wb_sel rf_we retire illegal
    function automatic logic [15:0] ov(input int imr, input int irw, input int dr, input int dw,
                                       input int pw, input int ps, input int as, input int bs,
                                       input int ad, input int ws, input int rw, input int rt,
                                       input int il);
        return {1'(imr), 1'(irw), 1'(dr), 1'(dw), 1'(pw), 2'(ps), 2'(as), 1'(bs),
                1'(ad), 2'(ws), 1'(rw), 1'(rt), 1'(il)};
    endfunction

    task automatic check(input string tag, input logic [15:0] expv);
        n_checks++;
        assert (outs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, outs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [15:0] ZERO  = 16'h0000;
    localparam logic [15:0] FETCH = 16'hC000;

    initial begin
        rst_n      = 1'b0;
        ir         = I_ADDI;
        br_taken   = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        #2; check("rst_idle", ZERO);
        step(); #1; check("rst_hold", ZERO);

        // ADDI x1,x0,5: F D E W
        rst_n = 1'b1; #1; check("addi_fetch", FETCH);
        step(); #1; check("addi_decode", ZERO);
        step(); #1; check("addi_exec", ov(0,0,0,0,0,0,0,1,0,0,0,0,0));
        step(); #1; check("addi_wb",   ov(0,0,0,0,1,0,0,1,0,0,1,1,0));

        // LW x2: dmem_ready three cycles late
        step(); ir = I_LW; #1; check("lw_fetch", FETCH);
        step(); #1; check("lw_decode", ZERO);
        step(); #1; check("lw_exec",  ov(0,0,0,0,0,0,0,1,1,0,0,0,0));
        step(); #1; check("lw_mem0",  ov(0,0,1,0,0,0,0,1,1,0,0,0,0));
        step(); #1; check("lw_mem1",  ov(0,0,1,0,0,0,0,1,1,0,0,0,0));
        step(); #1; check("lw_mem2",  ov(0,0,1,0,0,0,0,1,1,0,0,0,0));
        step(); dmem_ready = 1'b1; #1; check("lw_mem3", ov(0,0,1,0,0,0,0,1,1,0,0,0,0));
        step(); dmem_ready = 1'b0; #1; check("lw_wb", ov(0,0,0,0,1,0,0,1,1,1,1,1,0));

        // BEQ with one imem wait cycle, both branch outcomes
        step(); ir = I_BEQ; imem_ready = 1'b0; #1; check("beq_fetch_wait", 16'h8000);
        step(); imem_ready = 1'b1; #1; check("beq_fetch", FETCH);
        step(); #1; check("beq_decode", ZERO);
        step(); br_taken = 1'b1; #1; check("beq_taken", ov(0,0,0,0,1,1,0,0,0,0,0,1,0));
        br_taken = 1'b0; #1; check("beq_not_taken", ov(0,0,0,0,1,0,0,0,0,0,0,1,0));

        // JAL x0: rf_we gated by rd=x0, retire unchanged
        step(); ir = I_JAL0; #1; check("jal_fetch", FETCH);
        step(); #1; check("jal_decode", ZERO);
        step(); #1; check("jal_exec", ov(0,0,0,0,1,1,0,0,0,2,0,1,0));

        // AUIPC x1
        step(); ir = I_AUIPC; #1; check("auipc_fetch", FETCH);
        step(); #1; check("auipc_decode", ZERO);
        step(); #1; check("auipc_exec", ov(0,0,0,0,0,0,1,1,1,0,0,0,0));
        step(); #1; check("auipc_wb",   ov(0,0,0,0,1,0,1,1,1,0,1,1,0));

        // SW with ready in the same cycle the request rises
        step(); ir = I_SW; #1; check("sw_fetch", FETCH);
        step(); #1; check("sw_decode", ZERO);
        step(); #1; check("sw_exec", ov(0,0,0,0,0,0,0,1,1,0,0,0,0));
        step(); dmem_ready = 1'b1; #1; check("sw_mem_done", ov(0,0,1,1,1,0,0,1,1,0,0,1,0));

        // SW again, reset asserted while the data request is pending
        step(); dmem_ready = 1'b0; #1; check("sw2_fetch", FETCH);
        step(); #1; check("sw2_decode", ZERO);
        step(); #1; check("sw2_exec", ov(0,0,0,0,0,0,0,1,1,0,0,0,0));
        step(); #1; check("sw2_mem_wait", ov(0,0,1,1,0,0,0,1,1,0,0,0,0));
        rst_n = 1'b0; #1; check("sw2_rst_abort", ZERO);
        step(); #1; check("sw2_rst_hold", ZERO);
        ir = I_ZERO;
        rst_n = 1'b1; #1; check("rst_release_fetch", FETCH);

        // All-zero instruction traps and stays halted until reset
        step(); #1; check("ill_decode", ZERO);
        step(); #1; check("ill_trap0", 16'h0001);
        step(); #1; check("ill_trap1", 16'h0001);
        step(); #1; check("ill_trap2", 16'h0001);
        rst_n = 1'b0; #1; check("ill_rst_clear", ZERO);
        rst_n = 1'b1; #1; check("ill_refetch", FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
